// File: rtl/game_round_if.sv
// game_round_if: control inputs and round-status outputs of the round sequencer
interface game_round_if;
  logic [1:0] game_state;
  logic frame_tick;
  logic pause_key;
  logic player_hit;
  logic level_done;
  logic play_enable;
  logic game_exit;
  logic [2:0] round_state;
  logic [3:0] lives;
  logic [3:0] level;
  logic [15:0] frames_left;
  logic win;
  modport master (
    output game_state, frame_tick, pause_key, player_hit, level_done,
    input play_enable, game_exit, round_state, lives, level, frames_left, win
  );
  modport slave (
    input game_state, frame_tick, pause_key, player_hit, level_done,
    output play_enable, game_exit, round_state, lives, level, frames_left, win
  );
endinterface

// File: rtl/game_round_sequencer.sv
// game_round_sequencer: countdown/play/pause/clear/over sequencing and life accounting per round
module game_round_sequencer #(
  parameter int LIVES_INIT = 3,
  parameter int LEVELS = 4,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int ROUND_FRAMES = 3600,
  parameter int CLEAR_FRAMES = 120
) (
  input logic Clk,
  input logic Reset,
  game_round_if.slave g
);
  typedef enum logic [2:0] {IDLE, COUNTDOWN, PLAY, PAUSED, CLEAR, OVER} state_t;
  state_t state, n_state;
  logic [3:0] n_lives, n_level;
  logic [15:0] n_frames;
  logic n_win, pause_prev, pause_edge, last_tick;
  assign pause_edge = g.pause_key & ~pause_prev;
  assign last_tick = g.frame_tick && g.frames_left == 16'd1;
  assign g.round_state = state;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      g.lives <= 4'(LIVES_INIT);
      g.level <= 4'd0;
      g.frames_left <= 16'd0;
      g.win <= 1'b0;
      g.play_enable <= 1'b0;
      g.game_exit <= 1'b0;
      pause_prev <= 1'b0;
    end else begin
      state <= n_state;
      g.lives <= n_lives;
      g.level <= n_level;
      g.frames_left <= n_frames;
      g.win <= n_win;
      g.play_enable <= n_state == PLAY;
      g.game_exit <= n_state == OVER && state != OVER;
      pause_prev <= g.pause_key;
    end
  end
  always_comb begin
    n_state = state;
    n_lives = g.lives;
    n_level = g.level;
    n_frames = g.frames_left;
    n_win = g.win;
    case (state)
      IDLE:
        if (g.game_state == 2'b01) begin
          n_state = COUNTDOWN;
          n_frames = 16'(COUNTDOWN_FRAMES);
        end
      COUNTDOWN:
        if (g.frame_tick) begin
          n_state = last_tick ? PLAY : COUNTDOWN;
          n_frames = last_tick ? 16'(ROUND_FRAMES) : g.frames_left - 16'd1;
        end
      PLAY:
        if (g.level_done) begin
          n_state = (g.level == 4'(LEVELS - 1)) ? OVER : CLEAR;
          n_win = g.level == 4'(LEVELS - 1);
          n_frames = (g.level == 4'(LEVELS - 1)) ? g.frames_left : 16'(CLEAR_FRAMES);
        end else if (g.player_hit || last_tick) begin
          n_state = (g.lives > 4'd1) ? COUNTDOWN : OVER;
          n_lives = (g.lives > 4'd1) ? g.lives - 4'd1 : 4'd0;
          n_win = 1'b0;
          n_frames = (g.lives > 4'd1) ? 16'(COUNTDOWN_FRAMES) : g.frames_left;
        end else begin
          n_frames = g.frame_tick ? g.frames_left - 16'd1 : g.frames_left;
          n_state = pause_edge ? PAUSED : PLAY;
        end
      PAUSED: n_state = pause_edge ? PLAY : PAUSED;
      CLEAR:
        if (g.frame_tick) begin
          n_state = last_tick ? COUNTDOWN : CLEAR;
          n_level = last_tick ? g.level + 4'd1 : g.level;
          n_frames = last_tick ? 16'(COUNTDOWN_FRAMES) : g.frames_left - 16'd1;
        end
      default: n_state = OVER;
    endcase
    // leaving in_game aborts any round; OVER also exits here
    if (state != IDLE && g.game_state != 2'b01) n_state = IDLE;
    if (n_state == IDLE) begin
      n_lives = 4'(LIVES_INIT);
      n_level = 4'd0;
      n_win = 1'b0;
      n_frames = 16'd0;
    end
  end
endmodule

// File: tb/tb_game_round_sequencer.sv
// tb_game_round_sequencer: directed scenarios then random stimulus against a reference model
module tb_game_round_sequencer;
  localparam int LI = 2, LV = 2, CD = 3, RF = 10, CF = 2;
  localparam int S_IDLE = 0, S_CD = 1, S_PLAY = 2, S_PAUSE = 3, S_CLEAR = 4, S_OVER = 5;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int errors = 0;
  int m_state, m_lives, m_level, m_frames, m_win, m_pe, m_exit, m_prev;
  game_round_if ifc ();
  game_round_sequencer #(.LIVES_INIT(LI), .LEVELS(LV), .COUNTDOWN_FRAMES(CD),
    .ROUND_FRAMES(RF), .CLEAR_FRAMES(CF)) dut (.Clk(clk), .Reset(rst), .g(ifc));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic to_idle_values();
    m_lives = LI; m_level = 0; m_win = 0; m_frames = 0;
  endtask
  // round rules applied to one sampled input set
  task automatic model_step();
    int old;
    bit pedge, timeout;
    old = m_state;
    pedge = ifc.pause_key && !m_prev;
    timeout = ifc.frame_tick && m_frames == 1;
    m_prev = rst ? 0 : int'(ifc.pause_key);
    if (rst) begin
      m_state = S_IDLE; to_idle_values(); m_pe = 0; m_exit = 0;
      return;
    end
    if (m_state != S_IDLE && ifc.game_state != 2'b01) m_state = S_IDLE;
    else if (m_state == S_IDLE) begin
      if (ifc.game_state == 2'b01) begin m_state = S_CD; m_frames = CD; end
    end else if (m_state == S_CD) begin
      if (timeout) begin m_state = S_PLAY; m_frames = RF; end
      else if (ifc.frame_tick) m_frames--;
    end else if (m_state == S_PLAY) begin
      if (ifc.level_done) begin
        if (m_level == LV - 1) begin m_state = S_OVER; m_win = 1; end
        else begin m_state = S_CLEAR; m_frames = CF; end
      end else if (ifc.player_hit || timeout) begin
        if (m_lives > 1) begin m_lives--; m_state = S_CD; m_frames = CD; end
        else begin m_lives = 0; m_state = S_OVER; m_win = 0; end
      end else begin
        if (ifc.frame_tick) m_frames--;
        if (pedge) m_state = S_PAUSE;
      end
    end else if (m_state == S_PAUSE) begin
      if (pedge) m_state = S_PLAY;
    end else if (m_state == S_CLEAR) begin
      if (timeout) begin m_level++; m_state = S_CD; m_frames = CD; end
      else if (ifc.frame_tick) m_frames--;
    end
    if (m_state == S_IDLE) to_idle_values();
    m_pe = m_state == S_PLAY;
    m_exit = m_state == S_OVER && old != S_OVER;
  endtask
  task automatic step(input logic r, input logic [1:0] gs, input logic ft, input logic pk,
                      input logic ph, input logic ld);
    rst = r; ifc.game_state = gs; ifc.frame_tick = ft; ifc.pause_key = pk;
    ifc.player_hit = ph; ifc.level_done = ld;
    @(posedge clk);
    model_step();
    #1;
    chk("round_state", 32'(ifc.round_state), m_state);
    chk("lives", 32'(ifc.lives), m_lives);
    chk("level", 32'(ifc.level), m_level);
    chk("win", 32'(ifc.win), m_win);
    chk("play_enable", 32'(ifc.play_enable), m_pe);
    chk("game_exit", 32'(ifc.game_exit), m_exit);
    if (m_state != S_OVER) chk("frames_left", 32'(ifc.frames_left), m_frames);
  endtask
  task automatic ticks(input int n, input logic pk);
    for (int i = 0; i < n; i++) step(0, 2'b01, 1, pk, 0, 0);
  endtask
  initial begin
    m_state = S_IDLE; to_idle_values(); m_pe = 0; m_exit = 0; m_prev = 0;
    step(1, 2'b00, 0, 0, 0, 0);
    chk("reset_state", 32'(ifc.round_state), S_IDLE);
    chk("reset_lives", 32'(ifc.lives), LI);
    step(0, 2'b01, 0, 0, 0, 0);
    chk("cd_start", 32'(ifc.frames_left), CD);
    ticks(3, 0);
    chk("play_entry", 32'(ifc.round_state), S_PLAY);
    chk("play_frames", 32'(ifc.frames_left), RF);
    chk("play_en", 32'(ifc.play_enable), 1);
    step(0, 2'b01, 0, 0, 1, 0);
    chk("hit_lives", 32'(ifc.lives), 1);
    ticks(3, 0);
    ticks(10, 0);
    chk("timeout_over", 32'(ifc.round_state), S_OVER);
    chk("timeout_exit", 32'(ifc.game_exit), 1);
    step(0, 2'b01, 0, 0, 0, 0);
    chk("exit_one_cycle", 32'(ifc.game_exit), 0);
    step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b01, 0, 0, 0, 0);
    ticks(3, 0);
    step(0, 2'b01, 0, 0, 0, 1);
    chk("clear_entry", 32'(ifc.round_state), S_CLEAR);
    ticks(2, 0);
    chk("level_up", 32'(ifc.level), 1);
    ticks(3, 0);
    step(0, 2'b01, 0, 0, 0, 1);
    chk("win_set", 32'(ifc.win), 1);
    step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b01, 0, 0, 0, 0);
    ticks(3, 0);
    ticks(3, 0);
    step(0, 2'b01, 0, 1, 0, 0);
    chk("paused", 32'(ifc.round_state), S_PAUSE);
    step(0, 2'b01, 0, 0, 0, 0);
    ticks(4, 0);
    step(0, 2'b01, 1, 0, 1, 0);
    chk("pause_frozen", 32'(ifc.frames_left), 7);
    chk("pause_lives", 32'(ifc.lives), 2);
    step(0, 2'b01, 0, 1, 0, 0);
    chk("unpaused", 32'(ifc.round_state), S_PLAY);
    step(0, 2'b01, 0, 0, 1, 1);
    chk("ld_over_hit", 32'(ifc.round_state), S_CLEAR);
    chk("ld_lives", 32'(ifc.lives), 2);
    ticks(2, 0);
    ticks(3, 0);
    step(0, 2'b01, 0, 1, 1, 0);
    chk("hit_over_pause", 32'(ifc.round_state), S_CD);
    ticks(3, 0);
    step(0, 2'b10, 0, 0, 0, 0);
    chk("abort_idle", 32'(ifc.round_state), S_IDLE);
    chk("abort_no_exit", 32'(ifc.game_exit), 0);
    step(0, 2'b01, 0, 0, 0, 0);
    ticks(3, 0);
    step(0, 2'b01, 0, 0, 0, 1);
    step(1, 2'b01, 1, 0, 0, 0);
    chk("rst_clear_state", 32'(ifc.round_state), S_IDLE);
    chk("rst_clear_frames", 32'(ifc.frames_left), 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0,
           ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 2)) : 2'b01,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
